// File: rtl/updn_counter_pkg.sv
// ============================================================================
// Module      : updn_counter_pkg
// Description : Shared types and operation decode for the up/down counter bank.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package updn_counter_pkg;

  typedef enum logic [0:0] {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_INC  = 2'd1,
    OP_DEC  = 2'd2,
    OP_LOAD = 2'd3
  } cnt_op_e;

  // Load dominates; simultaneous incr and decr cancel to a hold.
  function automatic cnt_op_e decode_op(input logic load, input logic incr, input logic decr);
    if (load)
      return OP_LOAD;
    else if (incr && !decr)
      return OP_INC;
    else if (decr && !incr)
      return OP_DEC;
    else
      return OP_HOLD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/updn_counter_lane.sv
// ============================================================================
// Module      : updn_counter_lane
// Description : One up/down counter channel with wrap/saturate, sticky flags
//               and a registered boundary-crossing pulse.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module updn_counter_lane
  import updn_counter_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               STEP_WIDTH  = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  incr,
  input  logic                  decr,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic                  sat_mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  clear_flags,
  output logic [WIDTH-1:0]      count,
  output logic                  ovf,
  output logic                  unf,
  output logic                  cross_pulse,
  output logic                  is_zero,
  output logic                  is_max
);

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;
  logic             r_cross_pulse;

  cnt_op_e          w_op;
  cnt_mode_e        w_mode;
  logic [WIDTH-1:0] w_step_ext;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_next_count;
  logic             w_ovf_ev;
  logic             w_unf_ev;

  assign w_op   = decode_op(load, incr, decr);
  assign w_mode = sat_mode ? CNT_SAT : CNT_WRAP;

  always_comb begin
    w_step_ext                 = '0;
    w_step_ext[STEP_WIDTH-1:0] = step;
    w_sum                      = {1'b0, r_count} + {1'b0, w_step_ext};
    w_diff                     = {1'b0, r_count} - {1'b0, w_step_ext};
  end

  // The extra MSB of sum/diff is the carry/borrow that defines an event.
  always_comb begin
    w_next_count = r_count;
    w_ovf_ev     = 1'b0;
    w_unf_ev     = 1'b0;
    case (w_op)
      OP_LOAD: w_next_count = load_value;
      OP_INC: begin
        w_ovf_ev     = w_sum[WIDTH];
        w_next_count = (w_sum[WIDTH] && w_mode == CNT_SAT) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
      end
      OP_DEC: begin
        w_unf_ev     = w_diff[WIDTH];
        w_next_count = (w_diff[WIDTH] && w_mode == CNT_SAT) ? {WIDTH{1'b0}} : w_diff[WIDTH-1:0];
      end
      OP_HOLD: w_next_count = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count       <= RESET_VALUE;
      r_ovf         <= 1'b0;
      r_unf         <= 1'b0;
      r_cross_pulse <= 1'b0;
    end else begin
      r_count       <= w_next_count;
      r_ovf         <= w_ovf_ev | (r_ovf & ~clear_flags);
      r_unf         <= w_unf_ev | (r_unf & ~clear_flags);
      r_cross_pulse <= w_ovf_ev | w_unf_ev;
    end
  end

  assign count       = r_count;
  assign ovf         = r_ovf;
  assign unf         = r_unf;
  assign cross_pulse = r_cross_pulse;
  assign is_zero     = (r_count == {WIDTH{1'b0}});
  assign is_max      = (r_count == {WIDTH{1'b1}});

endmodule

`default_nettype wire

// File: rtl/updn_counter_bank.sv
// ============================================================================
// Module      : updn_counter_bank
// Description : Bank of independent up/down counters sharing clock, reset,
//               step and mode; packs per-lane buses.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module updn_counter_bank #(
  parameter int               WIDTH       = 32,
  parameter int               CHANNELS    = 4,
  parameter int               STEP_WIDTH  = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       incr,
  input  logic [CHANNELS-1:0]       decr,
  input  logic [STEP_WIDTH-1:0]     step,
  input  logic                      sat_mode,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_value,
  input  logic [CHANNELS-1:0]       clear_flags,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CHANNELS-1:0]       unf,
  output logic [CHANNELS-1:0]       cross_pulse,
  output logic [CHANNELS-1:0]       is_zero,
  output logic [CHANNELS-1:0]       is_max
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    updn_counter_lane #(
      .WIDTH       (WIDTH),
      .STEP_WIDTH  (STEP_WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .incr        (incr[i]),
      .decr        (decr[i]),
      .step        (step),
      .sat_mode    (sat_mode),
      .load        (load[i]),
      .load_value  (load_value[i*WIDTH +: WIDTH]),
      .clear_flags (clear_flags[i]),
      .count       (count[i*WIDTH +: WIDTH]),
      .ovf         (ovf[i]),
      .unf         (unf[i]),
      .cross_pulse (cross_pulse[i]),
      .is_zero     (is_zero[i]),
      .is_max      (is_max[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_updn_counter_bank.sv
// ============================================================================
// Module      : tb_updn_counter_bank
// Description : Directed vector bench for updn_counter_bank (WIDTH=8, 4 lanes).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_updn_counter_bank;

  localparam int C_W  = 8;
  localparam int C_CH = 4;
  localparam int C_SW = 8;
  localparam int C_NV = 21;

  logic                   clk;
  logic                   reset;
  logic [C_CH-1:0]        incr, decr, load, clear_flags;
  logic [C_SW-1:0]        step;
  logic                   sat_mode;
  logic [C_CH*C_W-1:0]    load_value;
  logic [C_CH*C_W-1:0]    count;
  logic [C_CH-1:0]        ovf, unf, cross_pulse, is_zero, is_max;

  int n_checks = 0;
  int n_fail   = 0;

  updn_counter_bank #(
    .WIDTH       (C_W),
    .CHANNELS    (C_CH),
    .STEP_WIDTH  (C_SW),
    .RESET_VALUE (8'h10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .incr        (incr),
    .decr        (decr),
    .step        (step),
    .sat_mode    (sat_mode),
    .load        (load),
    .load_value  (load_value),
    .clear_flags (clear_flags),
    .count       (count),
    .ovf         (ovf),
    .unf         (unf),
    .cross_pulse (cross_pulse),
    .is_zero     (is_zero),
    .is_max      (is_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  incr, decr, load, clr;
    logic [7:0]  step;
    logic        sat;
    logic [31:0] lv;
    logic [31:0] e_count;
    logic [3:0]  e_ovf, e_unf, e_pulse, e_zero, e_max;
  } vec_t;

  vec_t vecs [C_NV];

  function automatic vec_t mk(logic [3:0] i, logic [3:0] d, logic [3:0] l, logic [3:0] c,
                              logic [7:0] s, logic sm, logic [31:0] lv, logic [31:0] ec,
                              logic [3:0] eo, logic [3:0] eu, logic [3:0] ep,
                              logic [3:0] ez, logic [3:0] em);
    vec_t v;
    v.incr = i; v.decr = d; v.load = l; v.clr = c; v.step = s; v.sat = sm; v.lv = lv;
    v.e_count = ec; v.e_ovf = eo; v.e_unf = eu; v.e_pulse = ep; v.e_zero = ez; v.e_max = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] ec, input logic [3:0] eo,
                         input logic [3:0] eu, input logic [3:0] ep,
                         input logic [3:0] ez, input logic [3:0] em);
    chk({tag, ".count"}, count, ec);
    chk({tag, ".ovf"},   {28'd0, ovf}, {28'd0, eo});
    chk({tag, ".unf"},   {28'd0, unf}, {28'd0, eu});
    chk({tag, ".pulse"}, {28'd0, cross_pulse}, {28'd0, ep});
    chk({tag, ".zero"},  {28'd0, is_zero}, {28'd0, ez});
    chk({tag, ".max"},   {28'd0, is_max}, {28'd0, em});
  endtask

  task automatic idle_inputs();
    incr = '0; decr = '0; load = '0; clear_flags = '0;
    step = '0; sat_mode = 1'b0; load_value = '0;
  endtask

  initial begin
    //                incr     decr     load     clr      step   sat  load_value    count         ovf      unf      pulse    zero     max
    vecs[0]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'h03, 1'b0, 32'h0,        32'h10101013, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    vecs[1]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'h03, 1'b0, 32'h0,        32'h10101016, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    vecs[2]  = mk(4'b0000, 4'b0000, 4'b0110, 4'b0000, 8'h00, 1'b0, 32'h0002FE00, 32'h1002FE16, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    vecs[3]  = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 8'h05, 1'b0, 32'h0,        32'h10020316, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    vecs[4]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h05, 1'b0, 32'h0,        32'h10020316, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    vecs[5]  = mk(4'b0000, 4'b0000, 4'b0010, 4'b0000, 8'h00, 1'b0, 32'h0000FE00, 32'h1002FE16, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    vecs[6]  = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 8'h05, 1'b1, 32'h0,        32'h1002FF16, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010);
    vecs[7]  = mk(4'b0000, 4'b0100, 4'b0000, 4'b0000, 8'h04, 1'b1, 32'h0,        32'h1000FF16, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0010);
    vecs[8]  = mk(4'b0000, 4'b0000, 4'b0100, 4'b0000, 8'h00, 1'b0, 32'h00020000, 32'h1002FF16, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0010);
    vecs[9]  = mk(4'b0000, 4'b0100, 4'b0000, 4'b0000, 8'h04, 1'b0, 32'h0,        32'h10FEFF16, 4'b0010, 4'b0100, 4'b0100, 4'b0000, 4'b0010);
    vecs[10] = mk(4'b1000, 4'b1000, 4'b0000, 4'b0000, 8'h04, 1'b0, 32'h0,        32'h10FEFF16, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0010);
    vecs[11] = mk(4'b1000, 4'b0000, 4'b1000, 4'b0000, 8'h04, 1'b0, 32'h55000000, 32'h55FEFF16, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0010);
    vecs[12] = mk(4'b0000, 4'b0000, 4'b0001, 4'b0000, 8'h00, 1'b0, 32'h000000FE, 32'h55FEFFFE, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0010);
    vecs[13] = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'h05, 1'b0, 32'h0,        32'h55FEFF03, 4'b0011, 4'b0100, 4'b0001, 4'b0000, 4'b0010);
    vecs[14] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0001, 8'h00, 1'b0, 32'h0,        32'h55FEFF03, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0010);
    vecs[15] = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'hFF, 1'b0, 32'h0,        32'h55FEFF02, 4'b0011, 4'b0100, 4'b0001, 4'b0000, 4'b0010);
    vecs[16] = mk(4'b0001, 4'b0000, 4'b0000, 4'b0001, 8'hFF, 1'b0, 32'h0,        32'h55FEFF01, 4'b0011, 4'b0100, 4'b0001, 4'b0000, 4'b0010);
    vecs[17] = mk(4'b0000, 4'b0000, 4'b0101, 4'b1111, 8'h00, 1'b0, 32'h000000FE, 32'h5500FFFE, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0010);
    vecs[18] = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'h01, 1'b0, 32'h0,        32'h5500FFFF, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0011);
    vecs[19] = mk(4'b0010, 4'b0100, 4'b0000, 4'b0000, 8'h00, 1'b0, 32'h0,        32'h5500FFFF, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0011);
    vecs[20] = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'h01, 1'b1, 32'h0,        32'h5500FFFF, 4'b0001, 4'b0000, 4'b0001, 4'b0100, 4'b0011);

    reset = 1'b0;
    idle_inputs();

    // Asynchronous reset asserted between edges must take effect at once.
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1 chk_all("reset_async", 32'h10101010, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk_all("reset_release", 32'h10101010, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    for (int v = 0; v < C_NV; v++) begin
      incr = vecs[v].incr; decr = vecs[v].decr; load = vecs[v].load;
      clear_flags = vecs[v].clr; step = vecs[v].step; sat_mode = vecs[v].sat;
      load_value = vecs[v].lv;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", v), vecs[v].e_count, vecs[v].e_ovf, vecs[v].e_unf,
              vecs[v].e_pulse, vecs[v].e_zero, vecs[v].e_max);
    end

    // Reset mid-operation discards the pending load/increment.
    load = 4'b1111; load_value = 32'hAAAAAAAA; incr = 4'b1111; step = 8'h01;
    #3 reset = 1'b1;
    #1 chk_all("reset_mid", 32'h10101010, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    @(posedge clk); #1;
    chk_all("reset_held", 32'h10101010, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    idle_inputs();
    reset = 1'b0;
    @(posedge clk); #1;
    chk_all("post_reset_hold", 32'h10101010, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    incr = 4'b0001; step = 8'h01;
    @(posedge clk); #1;
    chk_all("post_reset_incr", 32'h10101011, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/updn_counter_bank.md
Name: updn_counter_bank

Overview:
- Bank of CHANNELS independent up/down counters, each WIDTH bits, sharing one clock and one reset.
- Successor to the single-channel incr/decr counter. Adds:
  - programmable step size;
  - per-channel synchronous load;
  - wrap or saturate mode;
  - sticky overflow/underflow flags;
  - one-cycle boundary-crossing pulses.
- Used for event/credit accounting in the library. Instantiated standalone or per-port.

Parameters:
- WIDTH, 32, bit width of each counter (≥2).
- CHANNELS, 4, number of independent counters (≥1).
- STEP_WIDTH, 8, width of the shared step input (1..WIDTH).
- RESET_VALUE, 0, value loaded into every counter on reset. Must fit in WIDTH bits.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- incr  in  CHANNELS  per-channel increment request.
- decr  in  CHANNELS  per-channel decrement request.
- step  in  STEP_WIDTH  shared step magnitude, unsigned, zero-extended to WIDTH.
- sat_mode  in  1  global mode: 0 = wrap modulo 2^WIDTH, 1 = saturate at 0 / 2^WIDTH-1.
- load  in  CHANNELS  per-channel synchronous load strobe.
- load_value  in  CHANNELS*WIDTH  packed load values; channel i uses bits [i*WIDTH +: WIDTH].
- clear_flags  in  CHANNELS  per-channel clear of sticky ovf/unf.
- count  out  CHANNELS*WIDTH  packed registered counter values.
- ovf  out  CHANNELS  sticky overflow flag.
- unf  out  CHANNELS  sticky underflow flag.
- cross_pulse  out  CHANNELS  one-cycle pulse, registered, on the cycle after any overflow/underflow event.
- is_zero  out  CHANNELS  combinational: count == 0.
- is_max  out  CHANNELS  combinational: count == 2^WIDTH-1.

Behaviour:
- Reset: asserting reset asynchronously forces, in every channel:
  - count = RESET_VALUE;
  - ovf = unf = cross_pulse = 0.
- Deassertion is sampled synchronously by the next clk edge. Reset mid-operation discards pending loads and steps.
- Per-channel priority each cycle: load > (incr XOR decr) > hold.
- load=1: count <= load_value[i].
  - incr/decr ignored; no flag update; cross_pulse <= 0.
  - clear_flags still honoured.
- incr=1 and decr=0: compute sum = {1'b0,count} + step in WIDTH+1 bits.
  - Carry set means an overflow event.
  - Wrap mode: count <= sum[WIDTH-1:0].
  - Saturate mode: count <= 2^WIDTH-1.
- decr=1 and incr=0: compute diff = {1'b0,count} - step in WIDTH+1 bits.
  - Borrow set means an underflow event.
  - Wrap mode: count <= diff[WIDTH-1:0].
  - Saturate mode: count <= 0.
- incr=decr=1 or both 0: count holds, no event.
- step=0 with incr or decr: count holds, no event.
- Landing exactly on 0 or max is not an event (e.g. 0xFF+0 or 0xFE+1 at WIDTH=8).
- Overflow event: ovf <= 1 and cross_pulse <= 1 in the same clk edge as the count update.
- Underflow event: unf <= 1 and cross_pulse <= 1 in the same clk edge as the count update.
- No event: cross_pulse <= 0.
- clear_flags[i]=1: ovf[i], unf[i] <= 0, unless the same cycle produces a new event; set wins over clear.
- Latency: count, flags and pulse update one clock after the request is sampled. is_zero/is_max follow count combinationally.
- Channels are fully independent; no cross-channel interaction.
- sat_mode may change any cycle and takes effect for that cycle's operation.

Decomposition:
- Package updn_counter_pkg holds:
  - enum cnt_mode_e {CNT_WRAP, CNT_SAT};
  - enum cnt_op_e {OP_HOLD, OP_INC, OP_DEC, OP_LOAD};
  - function decode_op(load, incr, decr) returning cnt_op_e.
- One natural sub-module, updn_counter_lane:
  - a single WIDTH-bit channel with the count/flag/pulse logic;
  - the bank instantiates CHANNELS lanes in a generate loop and packs/unpacks the buses.

Test Plan:
1. Reset and wrap:
   - Setup: WIDTH=8, RESET_VALUE=0x10. Assert reset asynchronously mid-cycle, then release.
   - Expect: count=0x10 on all channels immediately, flags=0.
   - Then: incr ch0, step=3, sat_mode=0, for 2 cycles → count0=0x16; other channels remain 0x10.
2. Overflow wrap/saturate:
   - Load ch1=0xFE, step=5, incr, sat_mode=0 → count1=0x03, ovf1=1, cross_pulse1 high exactly one cycle.
   - Repeat with sat_mode=1 → count1=0xFF, ovf1=1.
3. Underflow:
   - ch2=0x02, step=4, decr, sat_mode=1 → count2=0x00, unf2=1.
   - Then sat_mode=0 from 0x02 → count2=0xFE.
4. Simultaneous and priority:
   - ch3 incr=decr=1 → count unchanged, no pulse.
   - load=1 with incr=1, load_value=0x55 → count3=0x55, no flag change.
5. Flag clear race:
   - ovf0 set; assert clear_flags0 alone → ovf0=0 next cycle.
   - Assert clear_flags0 with a new overflow → ovf0 stays 1.
6. Boundary non-events:
   - count=0xFE, step=1, incr → 0xFF, is_max=1, ovf=0.
   - step=0 with decr at 0x00 → holds, unf=0, is_zero=1.
